mul8_acc: RTL and testbench

- Downstream consumer of the mul8_parall product stream (`p_o`, the upper byte of `a*b`).
- Re-aligns the operand-issue valid with the multiplier's fixed pipeline latency.
- Accumulates `ACC_LEN` consecutive valid products into one group sum.
- Presents each sum on a single-entry valid/ready output buffer, because the multiplier itself cannot be stalled.

---
 rtl/mul8_pkg.sv | 24 ++
 rtl/vld_dly.sv | 39 +++
 rtl/mul8_acc.sv | 192 +++++++++++++++++++
 tb/tb_mul8_acc.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul8_pkg.sv
// Shared definitions for the mul8 product-stream blocks: data width,
// multiplier pipeline latency, a constant-sizing helper and the output
// buffer state type.
package mul8_pkg;

   localparam int MUL8_DW  = 8;
   localparam int MUL8_LAT = 2;

   typedef enum logic {
      OB_EMPTY = 1'b0,
      OB_FULL  = 1'b1
   } ob_state_t;

   // Smallest r with 2**r >= v; used to size counters at elaboration time.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/vld_dly.sv
// Valid delay line: DEPTH-stage 1-bit shift register that keeps a valid
// aligned with data leaving the fixed-latency multiplier. DEPTH = 0 is a
// plain wire. any reports whether a valid is still in flight.
module vld_dly #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic d,
   output logic q,
   output logic any
);

   if (DEPTH == 0) begin : g_pass
      assign q   = d;
      assign any = 1'b0;
   end else begin : g_sr
      logic [DEPTH-1:0] sr;

      // shift the valid one stage per cycle; clear flushes everything in flight
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sr <= '0;
         end else if (clr) begin
            sr <= '0;
         end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
               sr[i] <= sr[i-1];
            end
         end
      end

      assign q   = sr[DEPTH-1];
      assign any = |sr;
   end

endmodule

// File: rtl/mul8_acc.sv
// Product-stream accumulator behind mul8_parall. Re-aligns the issue valid
// with the multiplier latency, sums ACC_LEN valid products per group and
// holds each group sum in a single-entry valid/ready buffer (the multiplier
// cannot stall, so a completion that finds the buffer full is dropped and
// flagged sticky on ovf_o).
//
// Optional feature macro ACC_SAT_EN: saturating accumulation with a
// per-group clamp flag reported on sum_sat_o. Undefined: wrap-around sum,
// sum_sat_o tied 0.
//
// Output buffer states:
//   state    | meaning
//   OB_EMPTY | no sum held, sum_vld_o = 0
//   OB_FULL  | sum_o holds an untransferred group sum, sum_vld_o = 1
module mul8_acc
   import mul8_pkg::*;
#(
   parameter int MUL_LAT = MUL8_LAT,
   parameter int ACC_LEN = 8,
   parameter int ACC_W   = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vld_i,
   input  logic               clr_i,
   input  logic [MUL8_DW-1:0] p_i,
   output logic [ACC_W-1:0]   sum_o,
   output logic               sum_vld_o,
   input  logic               sum_rdy_i,
   output logic               ovf_o,
   output logic               sum_sat_o,
   output logic               busy_o
);

   localparam int CNT_W = (clog2(ACC_LEN) < 1) ? 1 : clog2(ACC_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

   logic             pv;
   logic             dly_any;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nxt;
   logic [ACC_W-1:0] p_ext;
   logic [CNT_W-1:0] cnt;
   logic             done;
   logic             xfer;
   logic             load;
   logic             set_ovf;
   ob_state_t        state;
   ob_state_t        next_state;

   vld_dly #(
      .DEPTH(MUL_LAT)
   ) u_vld_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_i),
      .d     (vld_i),
      .q     (pv),
      .any   (dly_any)
   );

   assign p_ext = ACC_W'(p_i);
   assign done  = pv && (cnt == CNT_LAST);

`ifdef ACC_SAT_EN
   logic [ACC_W:0] add_wide;
   logic           clamp;
   logic           grp_sat;
   logic           grp_sat_nxt;
   logic           sum_sat_q;

   // saturating add; the group flag restarts on the first product of a group
   always_comb begin
      add_wide    = {1'b0, acc} + {1'b0, p_ext};
      clamp       = add_wide[ACC_W];
      acc_nxt     = clamp ? '1 : add_wide[ACC_W-1:0];
      grp_sat_nxt = ((cnt == '0) ? 1'b0 : grp_sat) | clamp;
   end

   // per-group clamp flag, tracked alongside acc
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grp_sat <= 1'b0;
      end else if (clr_i) begin
         grp_sat <= 1'b0;
      end else if (pv) begin
         grp_sat <= done ? 1'b0 : grp_sat_nxt;
      end
   end

   // saturation flag travels with the buffered sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_sat_q <= 1'b0;
      end else if (clr_i) begin
         sum_sat_q <= 1'b0;
      end else if (load) begin
         sum_sat_q <= grp_sat_nxt;
      end
   end

   assign sum_sat_o = sum_sat_q;
`else
   // wrap-around add modulo 2**ACC_W
   always_comb begin
      acc_nxt = acc + p_ext;
   end

   assign sum_sat_o = 1'b0;
`endif

   // accumulate valid products; the completing product restarts the group
   // on the same edge so the next product needs no dead cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (clr_i) begin
         acc <= '0;
         cnt <= '0;
      end else if (pv) begin
         if (done) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
         end
      end
   end

   // output buffer state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= OB_EMPTY;
      end else if (clr_i) begin
         state <= OB_EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // output buffer next state: load on completion when empty or draining,
   // otherwise drop the new sum and raise overflow
   always_comb begin
      next_state = state;
      load       = 1'b0;
      set_ovf    = 1'b0;
      xfer       = (state == OB_FULL) && sum_rdy_i;
      case (state)
         OB_EMPTY: begin
            if (done) begin
               load       = 1'b1;
               next_state = OB_FULL;
            end
         end
         OB_FULL: begin
            if (done) begin
               if (xfer) load = 1'b1;
               else      set_ovf = 1'b1;
            end else if (xfer) begin
               next_state = OB_EMPTY;
            end
         end
         default: next_state = OB_EMPTY;
      endcase
   end

   // buffered sum; left untouched by clear (only the valid is dropped)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_o <= '0;
      end else if (!clr_i && load) begin
         sum_o <= acc_nxt;
      end
   end

   // sticky overflow, released only by clear or reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_o <= 1'b0;
      end else if (clr_i) begin
         ovf_o <= 1'b0;
      end else if (set_ovf) begin
         ovf_o <= 1'b1;
      end
   end

   assign sum_vld_o = (state == OB_FULL);
   assign busy_o    = (cnt != '0) || dly_any;

endmodule

// File: tb/tb_mul8_acc.sv
// Bench for mul8_acc (MUL_LAT=2, ACC_LEN=8, ACC_W=10). A two-stage product
// pipeline stands in for mul8_parall; the reference keeps the products of
// the open group in a queue and sums them with plain arithmetic, and keeps
// the output buffer as a held value plus flags.
module tb_mul8_acc;

   localparam int ACC_W   = 10;
   localparam int ACC_LEN = 8;
   localparam int MUL_LAT = 2;
   localparam int ACC_MAX = (1 << ACC_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             vld_i;
   logic             clr_i;
   logic [7:0]       p_i;
   logic [ACC_W-1:0] sum_o;
   logic             sum_vld_o;
   logic             sum_rdy_i;
   logic             ovf_o;
   logic             sum_sat_o;
   logic             busy_o;

   mul8_acc #(
      .MUL_LAT (MUL_LAT),
      .ACC_LEN (ACC_LEN),
      .ACC_W   (ACC_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .vld_i     (vld_i),
      .clr_i     (clr_i),
      .p_i       (p_i),
      .sum_o     (sum_o),
      .sum_vld_o (sum_vld_o),
      .sum_rdy_i (sum_rdy_i),
      .ovf_o     (ovf_o),
      .sum_sat_o (sum_sat_o),
      .busy_o    (busy_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // multiplier stand-in: products in flight and whether the accumulator
   // still regards them as valid
   bit         mv[2];
   logic [7:0] mp[2];

   // reference state
   int grp[$];
   bit e_vld;
   bit e_ovf;
   bit e_sat;
   int e_sum;

   // stimulus controls
   bit         drv_vld;
   bit         drv_clr;
   bit         drv_rdy;
   logic [7:0] drv_p;
   int         vld_seen;
   logic [31:0] last_sum;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // group sum from the queued products
   task automatic group_result(output int s, output bit sat);
      s   = 0;
      sat = 1'b0;
      foreach (grp[i]) begin
         s = s + grp[i];
`ifdef ACC_SAT_EN
         if (s > ACC_MAX) begin
            s   = ACC_MAX;
            sat = 1'b1;
         end
`else
         s = s % (ACC_MAX + 1);
`endif
      end
   endtask

   // one clock: drive inputs, advance the reference, check after the edge
   task automatic tick();
      bit         pv;
      logic [7:0] pin;
      bit         xfer;
      bit         done;
      int         fs;
      bit         fsat;
      vld_i     = drv_vld;
      clr_i     = drv_clr;
      sum_rdy_i = drv_rdy;
      pv        = mv[1];
      pin       = pv ? mp[1] : 8'($urandom);
      p_i       = pin;
      xfer      = e_vld && drv_rdy;
      fs        = 0;
      fsat      = 1'b0;
      if (drv_clr) begin
         mv[0] = 1'b0;
         mv[1] = 1'b0;
         grp.delete();
         e_vld = 1'b0;
         e_ovf = 1'b0;
         e_sat = 1'b0;
      end else begin
         done = 1'b0;
         if (pv) begin
            grp.push_back(int'(pin));
            if (grp.size() == ACC_LEN) begin
               group_result(fs, fsat);
               grp.delete();
               done = 1'b1;
            end
         end
         if (done) begin
            if (!e_vld || xfer) begin
               e_sum = fs;
               e_sat = fsat;
               e_vld = 1'b1;
            end else begin
               e_ovf = 1'b1;
            end
         end else if (xfer) begin
            e_vld = 1'b0;
         end
         mv[1] = mv[0];
         mv[0] = drv_vld;
      end
      mp[1] = mp[0];
      mp[0] = drv_p;
      @(posedge clk);
      #1;
      chk("sum_vld", 32'(sum_vld_o), 32'(e_vld));
      chk("ovf", 32'(ovf_o), 32'(e_ovf));
      chk("busy", 32'(busy_o), 32'(grp.size() != 0 || mv[0] || mv[1]));
      if (e_vld) begin
         chk("sum", 32'(sum_o), 32'(e_sum));
         chk("sum_sat", 32'(sum_sat_o), 32'(e_sat));
      end
      if (sum_vld_o === 1'b1) begin
         vld_seen++;
         last_sum = 32'(sum_o);
      end
   endtask

   task automatic idle(input int n);
      drv_vld = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_group(input logic [7:0] p, input int n, input int max_bubble);
      for (int i = 0; i < n; i++) begin
         drv_vld = 1'b1;
         drv_p   = p;
         tick();
         drv_vld = 1'b0;
         if (max_bubble > 0) idle($urandom_range(0, max_bubble));
      end
      drv_vld = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      mv[0] = 1'b0;
      mv[1] = 1'b0;
      grp.delete();
      e_vld = 1'b0;
      e_ovf = 1'b0;
      e_sat = 1'b0;
      e_sum = 0;
      #2;
      chk({tag, "_sum"}, 32'(sum_o), 32'd0);
      chk({tag, "_vld"}, 32'(sum_vld_o), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf_o), 32'd0);
      chk({tag, "_sat"}, 32'(sum_sat_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_hold_vld"}, 32'(sum_vld_o), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] prod;
      rst_n     = 1'b1;
      vld_i     = 1'b0;
      clr_i     = 1'b0;
      sum_rdy_i = 1'b1;
      p_i       = 8'd0;
      drv_vld   = 1'b0;
      drv_clr   = 1'b0;
      drv_rdy   = 1'b1;
      drv_p     = 8'd0;
      mp[0]     = 8'd0;
      mp[1]     = 8'd0;
      vld_seen  = 0;
      last_sum  = 32'd0;
      #1;
      do_reset("rst0");

      // 8 issues of 0x45*0x55 -> upper byte 0x16, group sum 176
      prod = 16'h45 * 16'h55;
      run_group(prod[15:8], 8, 0);
      idle(2);
      chk("t1_vld_at_T+1", 32'(sum_vld_o), 32'd1);
      chk("t1_sum", 32'(sum_o), 32'd176);
      idle(1);
      chk("t1_vld_one_cycle", 32'(sum_vld_o), 32'd0);
      chk("t1_busy_after", 32'(busy_o), 32'd0);

      // 8 x 0xFF: wrap to 1016, or clamp to 1023 with the flag
      run_group(8'hFF, 8, 0);
      idle(2);
`ifdef ACC_SAT_EN
      chk("t2_sum", 32'(sum_o), 32'd1023);
      chk("t2_sat", 32'(sum_sat_o), 32'd1);
`else
      chk("t2_sum", 32'(sum_o), 32'd1016);
      chk("t2_sat", 32'(sum_sat_o), 32'd0);
`endif
      idle(1);

      // 8 x 0x10 with random bubbles: exactly one output of 128
      vld_seen = 0;
      run_group(8'h10, 8, 3);
      idle(4);
      chk("t3_once", 32'(vld_seen), 32'd1);
      chk("t3_sum", last_sum, 32'd128);

      // consumer stalled: first sum held, second completion dropped
      drv_rdy = 1'b0;
      run_group(8'h01, 16, 0);
      idle(3);
      chk("t4_sum_held", 32'(sum_o), 32'd8);
      chk("t4_vld_held", 32'(sum_vld_o), 32'd1);
      chk("t4_ovf", 32'(ovf_o), 32'd1);
      drv_rdy = 1'b1;
      idle(1);
      chk("t4_drained", 32'(sum_vld_o), 32'd0);
      chk("t4_ovf_sticky", 32'(ovf_o), 32'd1);

      // clear in the cycle the 8th product reaches p_i
      vld_seen = 0;
      run_group(8'h05, 8, 0);
      idle(1);
      drv_clr = 1'b1;
      tick();
      drv_clr = 1'b0;
      idle(2);
      chk("t6_no_vld", 32'(vld_seen), 32'd0);
      chk("t6_ovf_cleared", 32'(ovf_o), 32'd0);
      run_group(8'h03, 8, 0);
      idle(2);
      chk("t6_sum", 32'(sum_o), 32'd24);
      idle(1);

      // reset mid-group leaves no residue
      run_group(8'h20, 3, 0);
      idle(2);
      do_reset("t5_rst");
      run_group(8'h02, 8, 0);
      idle(2);
      chk("t5_sum", 32'(sum_o), 32'd16);
      idle(1);

      // random traffic, backpressure and occasional clears
      for (int i = 0; i < 600; i++) begin
         drv_vld = ($urandom_range(0, 3) != 0);
         drv_p   = 8'($urandom);
         drv_rdy = ($urandom_range(0, 2) != 0);
         drv_clr = ($urandom_range(0, 49) == 0);
         tick();
      end
      drv_clr = 1'b0;
      drv_rdy = 1'b1;
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
